pwm_ramp_ctrl: RTL and testbench

Multi-channel duty-cycle sequencer that drives a bank of 4-bit pwm instances. It accepts retarget commands over a valid/ready interface and steps each channel's duty value toward its target by one LSB per prescaler tick. This gives glitch-free brightness/drive fades for the downstream pwm datapath. It sits between the control FSM and the pwm bank, supplying each pwm's enable input and duty-select input.

---
 rtl/pwm_ramp_ctrl.sv | 120 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel duty sequencer: walks each pwm channel's duty select toward a
// commanded target one LSB per prescaler tick, or jumps to it on request.
module pwm_ramp_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int CH_WIDTH    = 2,
    parameter int DS_WIDTH    = 4,
    parameter int STEP_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [CH_WIDTH-1:0]          cmd_ch,
    input  logic [DS_WIDTH-1:0]          cmd_target,
    input  logic                         cmd_instant,
    output logic [CHANNELS-1:0]          pwm_en,
    output logic [CHANNELS*DS_WIDTH-1:0] pwm_ds,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS-1:0]          done_pulse
);
    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    localparam int                  PS_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_CYCLES - 1);
    localparam logic [DS_WIDTH-1:0] DS_MAX  = '1;

    logic [PS_W-1:0]              prescaler;
    logic                         tick;
    logic                         cmd_fire;
    logic [31:0]                  ch_idx;
    state_t                       state     [CHANNELS];
    state_t                       state_nxt [CHANNELS];
    logic [DS_WIDTH-1:0]          target    [CHANNELS];
    logic [DS_WIDTH-1:0]          cur;
    logic [DS_WIDTH-1:0]          stepped;
    logic [CHANNELS*DS_WIDTH-1:0] ds_nxt;
    logic [CHANNELS-1:0]          en_nxt;
    logic [CHANNELS-1:0]          busy_nxt;
    logic [CHANNELS-1:0]          done_nxt;

    // One LSB toward the target, clamped at the code range ends.
    function automatic logic [DS_WIDTH-1:0] step_toward(input logic [DS_WIDTH-1:0] val,
                                                        input logic up);
        if (up) begin
            return (val == DS_MAX) ? val : val + DS_WIDTH'(1);
        end
        return (val == '0) ? val : val - DS_WIDTH'(1);
    endfunction

    assign tick     = (prescaler == PS_LAST);
    assign cmd_fire = cmd_valid & cmd_ready;
    assign ch_idx   = 32'(cmd_ch);

    // A command to a channel takes priority over that channel's tick step.
    always_comb begin
        ds_nxt   = pwm_ds;
        en_nxt   = '0;
        busy_nxt = '0;
        done_nxt = '0;
        cur      = '0;
        stepped  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_nxt[i] = state[i];
            cur          = pwm_ds[i*DS_WIDTH +: DS_WIDTH];
            stepped      = step_toward(cur, state[i] == UP);
            if (cmd_fire && ch_idx == 32'(i)) begin
                if (cmd_instant || cmd_target == cur) begin
                    ds_nxt[i*DS_WIDTH +: DS_WIDTH] = cmd_target;
                    state_nxt[i] = IDLE;
                    done_nxt[i]  = 1'b1;
                end else if (cmd_target > cur) begin
                    state_nxt[i] = UP;
                end else begin
                    state_nxt[i] = DOWN;
                end
            end else if (tick && state[i] != IDLE) begin
                ds_nxt[i*DS_WIDTH +: DS_WIDTH] = stepped;
                if (stepped == target[i]) begin
                    state_nxt[i] = IDLE;
                    done_nxt[i]  = 1'b1;
                end
            end
            en_nxt[i]   = (ds_nxt[i*DS_WIDTH +: DS_WIDTH] != '0);
            busy_nxt[i] = (state_nxt[i] != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready  <= 1'b0;
            prescaler  <= '0;
            pwm_ds     <= '0;
            pwm_en     <= '0;
            busy       <= '0;
            done_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= IDLE;
            end
        end else begin
            cmd_ready  <= 1'b1;
            prescaler  <= tick ? '0 : prescaler + PS_W'(1);
            pwm_ds     <= ds_nxt;
            pwm_en     <= en_nxt;
            busy       <= busy_nxt;
            done_pulse <= done_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= state_nxt[i];
            end
        end
    end

    // Targets are only consulted while a channel is ramping, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (cmd_fire && ch_idx == 32'(i)) begin
                target[i] <= cmd_target;
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: a value/target model predicts every
// cycle's outputs; a monitor thread pops and compares on each falling edge.
module tb_pwm_ramp_ctrl;
    localparam int CHANNELS    = 4;
    localparam int CH_WIDTH    = 3;
    localparam int DS_WIDTH    = 4;
    localparam int STEP_CYCLES = 16;
    localparam int DSW         = CHANNELS * DS_WIDTH;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [CH_WIDTH-1:0] cmd_ch = '0;
    logic [DS_WIDTH-1:0] cmd_target = '0;
    logic                cmd_instant = 1'b0;
    logic [CHANNELS-1:0] pwm_en;
    logic [DSW-1:0]      pwm_ds;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done_pulse;

    pwm_ramp_ctrl #(
        .CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH),
        .DS_WIDTH(DS_WIDTH), .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_instant(cmd_instant),
        .pwm_en(pwm_en), .pwm_ds(pwm_ds), .busy(busy), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DSW-1:0]      ds;
        logic [CHANNELS-1:0] en;
        logic [CHANNELS-1:0] bsy;
        logic [CHANNELS-1:0] done;
        logic                ready;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    int                  m_cur [CHANNELS];
    int                  m_tgt [CHANNELS];
    bit                  m_mov [CHANNELS];
    bit                  m_ready;
    int                  m_pcount;
    logic [CHANNELS-1:0] m_done;

    int dn_cnt     [CHANNELS];
    bit busy_seen  [CHANNELS];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: each channel is just a value, a goal and a "moving" flag; ticks fall
    // on every STEP_CYCLES-th edge counted from reset release.
    task automatic model_edge(input bit rst, input bit v, input int ch, input int tgt, input bit inst);
        bit tick;
        m_done = '0;
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                m_cur[c] = 0; m_tgt[c] = 0; m_mov[c] = 0;
            end
            m_ready  = 0;
            m_pcount = 0;
            return;
        end
        tick = ((m_pcount % STEP_CYCLES) == STEP_CYCLES - 1);
        m_pcount++;
        for (int c = 0; c < CHANNELS; c++) begin
            if (v && m_ready && ch == c) begin
                m_tgt[c] = tgt;
                if (inst || tgt == m_cur[c]) begin
                    m_cur[c] = tgt; m_mov[c] = 0; m_done[c] = 1'b1;
                end else begin
                    m_mov[c] = 1;
                end
            end else if (tick && m_mov[c]) begin
                m_cur[c] += (m_tgt[c] > m_cur[c]) ? 1 : -1;
                if (m_cur[c] == m_tgt[c]) begin
                    m_mov[c] = 0; m_done[c] = 1'b1;
                end
            end
        end
        m_ready = 1;
    endtask

    task automatic cyc(input bit rst, input bit v, input int ch, input int tgt, input bit inst);
        snap_t s;
        reset       = rst;
        cmd_valid   = v;
        cmd_ch      = CH_WIDTH'(ch);
        cmd_target  = DS_WIDTH'(tgt);
        cmd_instant = inst;
        model_edge(rst, v, ch, tgt, inst);
        s.ds = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s.ds[c*DS_WIDTH +: DS_WIDTH] = DS_WIDTH'(m_cur[c]);
            s.en[c]  = (m_cur[c] != 0);
            s.bsy[c] = m_mov[c];
        end
        s.done  = m_done;
        s.ready = m_ready;
        @(posedge clk);
        exp_q.push_back(s);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic cmd(input int ch, input int tgt, input bit inst);
        cyc(0, 1, ch, tgt, inst);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] ds_of(input int c);
        return 32'(pwm_ds[c*DS_WIDTH +: DS_WIDTH]);
    endfunction

    task automatic clear_counts();
        for (int c = 0; c < CHANNELS; c++) begin
            dn_cnt[c] = 0; busy_seen[c] = 0;
        end
    endtask

    function automatic int total_done();
        int t = 0;
        for (int c = 0; c < CHANNELS; c++) t += dn_cnt[c];
        return t;
    endfunction

    // Bounded wait for the model to reach a value, then confirm on the DUT.
    task automatic wait_cur(input int ch, input int val, input int budget);
        int n = 0;
        while (m_cur[ch] != val && n < budget) begin
            idle(1);
            n++;
        end
        drain();
        check("reach_value", ds_of(ch), 32'(val));
    endtask

    initial begin
        clear_counts();
        fork
            forever begin : monitor
                snap_t e;
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pwm_ds",     32'(pwm_ds),     32'(e.ds));
                    check("pwm_en",     32'(pwm_en),     32'(e.en));
                    check("busy",       32'(busy),       32'(e.bsy));
                    check("done_pulse", 32'(done_pulse), 32'(e.done));
                    check("cmd_ready",  32'(cmd_ready),  32'(e.ready));
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (done_pulse[c] === 1'b1) dn_cnt[c]++;
                        if (busy[c] === 1'b1) busy_seen[c] = 1;
                    end
                end
            end
        join_none

        // Reset and idle
        repeat (3) cyc(1, 0, 0, 0, 0);
        idle(10);
        drain();
        check("ready_after_reset", 32'(cmd_ready), 32'd1);
        check("idle_ds", 32'(pwm_ds), 32'd0);
        clear_counts();

        // Full ramp 0 -> 15 on channel 0
        cmd(0, 15, 0);
        wait_cur(0, 15, 15 * STEP_CYCLES + 20);
        idle(5);
        drain();
        check("ramp_done_cnt", 32'(dn_cnt[0]), 32'd1);

        // Instant jump on channel 1: 8 then 0, never busy
        cmd(1, 8, 1);
        idle(2);
        drain();
        clear_counts();
        cmd(1, 0, 1);
        idle(3);
        drain();
        check("instant_done_cnt", 32'(dn_cnt[1]), 32'd1);
        check("instant_no_busy", 32'(busy_seen[1]), 32'd0);
        check("instant_en", 32'(pwm_en[1]), 32'd0);

        // Reverse mid-ramp at 6 toward 2
        cmd(0, 0, 1);
        idle(2);
        cmd(0, 15, 0);
        wait_cur(0, 6, 8 * STEP_CYCLES);
        clear_counts();
        cmd(0, 2, 0);
        wait_cur(0, 2, 6 * STEP_CYCLES);
        idle(40);
        drain();
        check("reverse_done_cnt", 32'(dn_cnt[0]), 32'd1);

        // Concurrent ramps; hold ch2 at 9 with a command landing on a tick
        cmd(2, 12, 0);
        cmd(3, 4, 0);
        wait_cur(2, 9, 12 * STEP_CYCLES);
        while ((m_pcount % STEP_CYCLES) != STEP_CYCLES - 1) idle(1);
        clear_counts();
        cmd(2, 9, 0);
        idle(3);
        drain();
        check("hold_done_cnt", 32'(dn_cnt[2]), 32'd1);
        idle(40);
        drain();
        check("hold_value", ds_of(2), 32'd9);
        check("ch3_final", ds_of(3), 32'd4);

        // Reset mid-ramp, then an out-of-range channel
        cmd(0, 0, 1);
        cmd(0, 15, 0);
        wait_cur(0, 7, 8 * STEP_CYCLES);
        clear_counts();
        cyc(1, 0, 0, 0, 0);
        idle(3);
        drain();
        check("rst_ds", 32'(pwm_ds), 32'd0);
        check("rst_done_cnt", 32'(total_done()), 32'd0);
        cmd(5, 9, 0);
        idle(40);
        drain();
        check("oor_ds", 32'(pwm_ds), 32'd0);
        check("oor_busy", 32'(busy), 32'd0);
        check("oor_done_cnt", 32'(total_done()), 32'd0);

        // Random commands, retargets and occasional resets
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                cyc(1, 0, 0, 0, 0);
            end else begin
                cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 4) == 0));
            end
            idle(int'($urandom_range(0, 40)));
        end
        idle(2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
